// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: holds the PC, fetches one instruction per retire and latches it for decode, with a fetch-timeout error.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:2] NPC,
  input  logic        pc_en,
  output logic        imem_req,
  output logic [31:2] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:2] PC,
  output logic [31:0] dout,
  output logic        instr_valid,
  output logic        bus_err,
  output logic [31:0] fetch_cnt
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, ERR} state_t;
  state_t state, state_nx;
  logic [CW-1:0] wait_cnt;
  logic timeout, accept, retire;
  assign timeout     = wait_cnt == CW'(TIMEOUT);
  assign accept      = state == FETCH && imem_ack;
  assign retire      = state == EXEC && pc_en;
  assign imem_req    = state == FETCH;
  assign instr_valid = state == EXEC;
  assign bus_err     = state == ERR;
  assign imem_addr   = PC;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = FETCH;
      FETCH:   state_nx = imem_ack ? EXEC : timeout ? ERR : FETCH;
      EXEC:    state_nx = pc_en ? FETCH : EXEC;
      default: state_nx = ERR;
    endcase
  end
  // the wait counter only runs inside FETCH, so every FETCH entry sees it at zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      PC        <= RESET_PC[31:2];
      dout      <= '0;
      fetch_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= (state == FETCH && !imem_ack && !timeout) ? wait_cnt + 1'b1 : '0;
      if (accept) dout <= imem_rdata;
      if (retire) begin
        PC        <= NPC;
        fetch_cnt <= fetch_cnt + 1'b1;
      end
    end
  end
endmodule
